vector_frame_writer: RTL and testbench
======================================

Name: vector_frame_writer

Overview:
- Producer side of the vector frame memory: accepts a stream of vector commands (point/line entries) and writes them as packed words into the frame RAM that the vector display reads and draws.
- Fills addresses FRAME_MIN..FRAME_MAX in order.
- Pads unused entries after the last command with non-drawing "hold" words, so the display loop never draws stale vectors.
- Sits between the target/scene generator and the write port of the dual-port vector RAM.

Parameters:
- ADDRESSWIDTH, 8, RAM address width.
- DATAWIDTH, 18, RAM word width; layout is {y[17:10], x[9:2], line[1], pos[0]}.
- OUT_WIDTH, 8, coordinate width.
- FRAME_MIN, VECTOR_MIN (from vector_pkg), first frame address.
- FRAME_MAX, VECTOR_MAX (from vector_pkg), last frame address; FRAME_MAX >= FRAME_MIN required.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  level; starts a new frame when the block is idle
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command this cycle
- cmd_x  in  OUT_WIDTH  target x
- cmd_y  in  OUT_WIDTH  target y
- cmd_line  in  1  1 = draw line to point, 0 = move
- cmd_pos  in  1  position flag, passed through to the word
- cmd_last  in  1  final command of the frame
- mem_addr  out  ADDRESSWIDTH  RAM write address
- mem_data  out  DATAWIDTH  RAM write data
- mem_we  out  1  RAM write enable
- frame_done  out  1  one-cycle pulse, frame fully written
- truncated  out  1  sticky: frame closed by full RAM before cmd_last

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; cmd_ready, mem_we, frame_done, truncated = 0; mem_addr=FRAME_MIN; mem_data=0; last word register = 0. Reset mid-frame abandons the frame with no further writes.
- FSM states: IDLE, WRITE, PAD, DONE.
- IDLE:
  - cmd_ready=0.
  - If enable=1: go to WRITE next cycle, write pointer = FRAME_MIN, truncated cleared.
- WRITE:
  - cmd_ready=1 combinationally.
  - Handshake = cmd_valid & cmd_ready.
  - On handshake, the registered outputs next cycle are mem_we=1, mem_addr=ptr, mem_data={cmd_y, cmd_x, cmd_line, cmd_pos}.
  - The same word is stored as the last word; ptr increments.
  - Write latency: 1 cycle from handshake to mem_we.
- WRITE transitions on handshake:
  - ptr==FRAME_MAX: go to DONE; set truncated=1 if cmd_last=0.
  - Else if cmd_last=1: go to PAD.
  - Else stay in WRITE.
  - Without a handshake, stay in WRITE and keep mem_we=0.
- PAD:
  - cmd_ready=0.
  - Each cycle, write the last word with line bit forced to 0 at ptr, then increment ptr.
  - Leave for DONE after writing FRAME_MAX.
  - Padding takes exactly FRAME_MAX-ptr+1 cycles.
- DONE:
  - frame_done=1 for exactly one cycle, aligned to the cycle after the final mem_we.
  - Then go to IDLE.
  - If enable is still 1 in IDLE, the next frame starts on the following cycle.
- Pointer arithmetic: width ADDRESSWIDTH; ptr never exceeds FRAME_MAX and never wraps.
- Exactly-full frame: cmd_last on the FRAME_MAX word closes the frame with no padding and truncated=0.
- Commands presented while cmd_ready=0 are neither consumed nor lost; the producer holds them.
- cmd_x/y/line/pos/last are sampled only on a handshake.
- enable is ignored outside IDLE; dropping enable mid-frame does not abort the frame.
- mem_we is never asserted in IDLE or DONE.

Optional Feature:
- Macro: VECTOR_BANK_SWAP_EN.
- Defined:
  - Adds output bank_sel (1 bit, reset 0).
  - mem_addr MSB is driven by the write bank = ~bank_sel.
  - bank_sel toggles in the DONE cycle, so the display reads the bank just completed while the writer fills the other.
  - FRAME_MIN/FRAME_MAX apply to the lower ADDRESSWIDTH-1 bits.
- Not defined:
  - No bank_sel port; the full address space is a single buffer.

Decomposition:
- vector_pkg holds:
  - VECTOR_MIN, VECTOR_MAX, DAC_WIDTH.
  - New typedef vector_word_t: packed struct {y, x, line, pos} matching the 18-bit layout.
  - New enum wr_state_t {IDLE, WRITE, PAD, DONE}.
- No sub-module: the FSM, pointer and output registers live in one module.

Test Plan:
- Nominal frame, FRAME_MIN=0, FRAME_MAX=7, enable=1, 3 commands, last on the third: writes at 0,1,2 with input words; addresses 3..7 hold the third word with bit1=0; frame_done pulses one cycle after the addr-7 write; truncated=0.
- Exactly full: 8 commands, last on the eighth: no PAD cycles; frame_done follows the addr-7 write; truncated=0.
- Overflow: 10 commands, none last: frame closes after addr 7 with truncated=1; commands 9–10 stall (cmd_ready=0) until enable restarts, then are written at 0 and 1.
- Backpressure and gaps: cmd_valid toggles every other cycle: mem_we only on the cycle after each handshake; addresses contiguous.
- Reset mid-PAD: rst low at pad addr 4: mem_we drops immediately; all outputs return to reset values; no frame_done.
- With VECTOR_BANK_SWAP_EN: two consecutive frames: first written with addr MSB=1 and bank_sel 0→1 at DONE; second written with MSB=0.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and limits for the vector frame memory: word layout, writer FSM states
// and the default frame window.
package vector_pkg;

  localparam int VECTOR_MIN = 0;
  localparam int VECTOR_MAX = 127;
  localparam int DAC_WIDTH  = 8;

  // RAM word layout, MSB first: {y, x, line, pos}
  typedef struct packed {
    logic [DAC_WIDTH-1:0] y;
    logic [DAC_WIDTH-1:0] x;
    logic                 line;
    logic                 pos;
  } vector_word_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    PAD,
    DONE
  } wr_state_t;

  // A padding word parks the beam on the last target without drawing.
  function automatic vector_word_t hold_word(input vector_word_t w);
    vector_word_t h;
    h      = w;
    h.line = 1'b0;
    return h;
  endfunction

endpackage

// File: rtl/vector_frame_writer_if.sv
// Command stream and RAM write port of the vector frame writer.
// slave = the writer itself, master = the command producer / RAM side.
interface vector_frame_writer_if #(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 18,
  parameter int OUT_WIDTH    = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [OUT_WIDTH-1:0]    cmd_x;
  logic [OUT_WIDTH-1:0]    cmd_y;
  logic                    cmd_line;
  logic                    cmd_pos;
  logic                    cmd_last;
  logic [ADDRESSWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0]    mem_data;
  logic                    mem_we;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_line, cmd_pos, cmd_last,
    output cmd_ready, mem_addr, mem_data, mem_we
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_line, cmd_pos, cmd_last,
    input  cmd_ready, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/vector_frame_writer.sv
// Writes one frame of vector commands into the frame RAM, padding the tail with hold words.
// Optional double buffering with VECTOR_BANK_SWAP_EN (adds bank_sel, address MSB = write bank).
module vector_frame_writer
  import vector_pkg::*;
#(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 18,
  parameter int OUT_WIDTH    = 8,
  parameter int FRAME_MIN    = VECTOR_MIN,
  parameter int FRAME_MAX    = VECTOR_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  vector_frame_writer_if.slave bus,
  output logic                 frame_done,
  output logic                 truncated
`ifdef VECTOR_BANK_SWAP_EN
  ,
  output logic                 bank_sel
`endif
);

`ifdef VECTOR_BANK_SWAP_EN
  localparam int PW = ADDRESSWIDTH - 1;
`else
  localparam int PW = ADDRESSWIDTH;
`endif
  localparam logic [PW-1:0] PTR_MIN = PW'(FRAME_MIN);
  localparam logic [PW-1:0] PTR_MAX = PW'(FRAME_MAX);

  wr_state_t               state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDRESSWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0]    mem_data_q, mem_data_d;
  vector_word_t            last_q, last_d;
  logic                    done_q, done_d;
  logic                    trunc_q, trunc_d;
  logic [ADDRESSWIDTH-1:0] wr_addr;
  vector_word_t            cmd_word;
  vector_word_t            pad_word;

`ifdef VECTOR_BANK_SWAP_EN
  logic bank_q;
  // The writer always fills the bank the display is not reading.
  assign wr_addr = {~bank_q, ptr_q};
  assign bank_sel = bank_q;
`else
  assign wr_addr = ptr_q;
`endif

  always_comb begin
    cmd_word      = '0;
    cmd_word.y    = DAC_WIDTH'(bus.cmd_y);
    cmd_word.x    = DAC_WIDTH'(bus.cmd_x);
    cmd_word.line = bus.cmd_line;
    cmd_word.pos  = bus.cmd_pos;
  end

  assign pad_word = hold_word(last_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    last_d     = last_q;
    trunc_d    = trunc_q;
    done_d     = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WRITE;
          ptr_d   = PTR_MIN;
          trunc_d = 1'b0;
        end
      end
      WRITE: begin
        if (bus.cmd_valid) begin
          mem_we_d   = 1'b1;
          mem_addr_d = wr_addr;
          mem_data_d = DATAWIDTH'(cmd_word);
          last_d     = cmd_word;
          // A full RAM wins over cmd_last; ptr stays parked at the top.
          if (ptr_q == PTR_MAX) begin
            state_d = DONE;
            trunc_d = ~bus.cmd_last;
          end else begin
            ptr_d = ptr_q + 1'b1;
            if (bus.cmd_last) state_d = PAD;
          end
        end
      end
      PAD: begin
        mem_we_d   = 1'b1;
        mem_addr_d = wr_addr;
        mem_data_d = DATAWIDTH'(pad_word);
        if (ptr_q == PTR_MAX) state_d = DONE;
        else                  ptr_d   = ptr_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_MIN;
      mem_we_q   <= 1'b0;
      mem_addr_q <= ADDRESSWIDTH'(FRAME_MIN);
      mem_data_q <= '0;
      last_q     <= '0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
`ifdef VECTOR_BANK_SWAP_EN
      bank_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      last_q     <= last_d;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
`ifdef VECTOR_BANK_SWAP_EN
      if (state_q == DONE) bank_q <= ~bank_q;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == WRITE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign frame_done    = done_q;
  assign truncated     = trunc_q;

endmodule

// File: tb/tb_vector_frame_writer.sv
// Directed bench for vector_frame_writer with an 8-entry frame (0..7).
// Bank-swap checks are active when VECTOR_BANK_SWAP_EN is defined.
module tb_vector_frame_writer;
  localparam int AW = 8, DW = 18, OW = 8, FMIN = 0, FMAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic frame_done, truncated;
`ifdef VECTOR_BANK_SWAP_EN
  logic bank_sel;
`endif
  logic exp_bank_sel = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  vector_frame_writer_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .OUT_WIDTH(OW)) bus ();

  vector_frame_writer #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .OUT_WIDTH(OW),
    .FRAME_MIN(FMIN), .FRAME_MAX(FMAX)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .frame_done(frame_done), .truncated(truncated)
`ifdef VECTOR_BANK_SWAP_EN
    , .bank_sel(bank_sel)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] ea(input int a);
`ifdef VECTOR_BANK_SWAP_EN
    logic [AW-2:0] low;
    low = (AW-1)'(a);
    return {~exp_bank_sel, low};
`else
    return AW'(a);
`endif
  endfunction

  function automatic logic [DW-1:0] word(input logic [7:0] y, input logic [7:0] x,
                                         input logic l, input logic p);
    return {y, x, l, p};
  endfunction

  task automatic start_frame();
    enable = 1'b1;
    check("idle_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    enable = 1'b0;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic l,
                      input logic p, input logic last, input int a);
    bus.cmd_x = x; bus.cmd_y = y; bus.cmd_line = l; bus.cmd_pos = p;
    bus.cmd_last = last; bus.cmd_valid = 1'b1;
    check("write_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_last  = 1'b0;
    $display("txn cmd  addr=%02h data=%05h we=%0b", bus.mem_addr, bus.mem_data, bus.mem_we);
    check("cmd_we", 32'(bus.mem_we), 32'd1);
    check("cmd_addr", 32'(bus.mem_addr), 32'(ea(a)));
    check("cmd_data", 32'(bus.mem_data), 32'(word(y, x, l, p)));
  endtask

  task automatic pad(input int a, input logic [DW-1:0] w);
    check("pad_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    $display("txn pad  addr=%02h data=%05h we=%0b", bus.mem_addr, bus.mem_data, bus.mem_we);
    check("pad_we", 32'(bus.mem_we), 32'd1);
    check("pad_addr", 32'(bus.mem_addr), 32'(ea(a)));
    check("pad_data", 32'(bus.mem_data), 32'(w));
  endtask

  task automatic finish_frame(input logic tr);
    tick();
    $display("txn done frame_done=%0b truncated=%0b", frame_done, truncated);
    check("done_pulse", 32'(frame_done), 32'd1);
    check("done_we", 32'(bus.mem_we), 32'd0);
    check("done_trunc", 32'(truncated), 32'(tr));
    exp_bank_sel = ~exp_bank_sel;
`ifdef VECTOR_BANK_SWAP_EN
    check("bank_sel", 32'(bank_sel), 32'(exp_bank_sel));
`endif
    tick();
    check("done_once", 32'(frame_done), 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_line = 1'b0; bus.cmd_pos = 1'b0; bus.cmd_last = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'(FMIN));
    check("rst_data", 32'(bus.mem_data), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_trunc", 32'(truncated), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_stays", 32'(bus.cmd_ready), 32'd0);

    // Nominal: 3 commands, last on the third, pad 3..7
    start_frame();
    send(8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 0);
    send(8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1);
    send(8'h55, 8'h66, 1'b1, 1'b1, 1'b1, 2);
    for (int a = 3; a <= FMAX; a++) pad(a, word(8'h66, 8'h55, 1'b0, 1'b1));
    finish_frame(1'b0);

    // Exactly full: 8 commands, last on the eighth, no padding
    start_frame();
    for (int i = 0; i < 8; i++)
      send(8'(i * 16 + 1), 8'(8'hA0 + i), 1'b1, i[0], (i == 7), i);
    finish_frame(1'b0);

    // Overflow: 8 commands without last, then 9 and 10 stall until restart
    start_frame();
    for (int i = 0; i < 8; i++)
      send(8'(8'h10 + i), 8'(8'h80 + i), i[1], 1'b0, 1'b0, i);
    finish_frame(1'b1);
    bus.cmd_x = 8'hC9; bus.cmd_y = 8'h9C; bus.cmd_line = 1'b1; bus.cmd_valid = 1'b1;
    check("stall_ready0", 32'(bus.cmd_ready), 32'd0);
    tick();
    check("stall_ready1", 32'(bus.cmd_ready), 32'd0);
    check("stall_we", 32'(bus.mem_we), 32'd0);
    check("trunc_sticky", 32'(truncated), 32'd1);
    start_frame();
    check("trunc_cleared", 32'(truncated), 32'd0);
    send(8'hC9, 8'h9C, 1'b1, 1'b0, 1'b0, 0);
    send(8'hCA, 8'hAC, 1'b1, 1'b1, 1'b1, 1);
    for (int a = 2; a <= FMAX; a++) pad(a, word(8'hAC, 8'hCA, 1'b0, 1'b1));
    finish_frame(1'b0);

    // Backpressure: valid every other cycle
    start_frame();
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h40 + i), 8'(8'h50 + i), 1'b1, 1'b0, (i == 3), i);
      if (i < 3) begin
        tick();
        check("gap_we", 32'(bus.mem_we), 32'd0);
      end
    end
    for (int a = 4; a <= FMAX; a++) pad(a, word(8'h53, 8'h43, 1'b0, 1'b0));
    finish_frame(1'b0);

    // Reset while padding at address 4
    start_frame();
    send(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 0);
    send(8'h03, 8'h04, 1'b1, 1'b1, 1'b1, 1);
    pad(2, word(8'h04, 8'h03, 1'b0, 1'b1));
    pad(3, word(8'h04, 8'h03, 1'b0, 1'b1));
    rst = 1'b0;
    #1;
    exp_bank_sel = 1'b0;
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_addr", 32'(bus.mem_addr), 32'(FMIN));
    check("mid_rst_data", 32'(bus.mem_data), 32'd0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
`ifdef VECTOR_BANK_SWAP_EN
    check("mid_rst_bank", 32'(bank_sel), 32'd0);
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_done", 32'(frame_done), 32'd0);
      check("post_rst_we", 32'(bus.mem_we), 32'd0);
    end

    // Two back-to-back frames: bank alternates when the swap option is built in
    for (int f = 0; f < 2; f++) begin
      start_frame();
      send(8'(8'hE0 + f), 8'(8'hF0 + f), 1'b1, 1'b1, 1'b1, 0);
      for (int a = 1; a <= FMAX; a++) pad(a, word(8'(8'hF0 + f), 8'(8'hE0 + f), 1'b0, 1'b1));
      finish_frame(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
